// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM state encoding,
// RV32 opcode/funct7 constants, ALU operation codes and the instruction
// field layout. Imported by ctrl_alu_decode and multicycle_control_unit.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int unsigned ALU_CODE_W = 5;
  typedef logic [ALU_CODE_W-1:0] alu_code_t;

  localparam alu_code_t ALU_ADD  = 5'h00;
  localparam alu_code_t ALU_SUB  = 5'h01;
  localparam alu_code_t ALU_SLL  = 5'h02;
  localparam alu_code_t ALU_SLT  = 5'h03;
  localparam alu_code_t ALU_SLTU = 5'h04;
  localparam alu_code_t ALU_XOR  = 5'h05;
  localparam alu_code_t ALU_SRL  = 5'h06;
  localparam alu_code_t ALU_SRA  = 5'h07;
  localparam alu_code_t ALU_OR   = 5'h08;
  localparam alu_code_t ALU_AND  = 5'h09;
  localparam alu_code_t ALU_MUL  = 5'h10; // MUL..REMU occupy 0x10-0x17

  // R-type instruction field layout (other formats reuse the same bit slots)
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

  // Base integer ALU op from funct3; alt selects SUB/SRA
  function automatic alu_code_t base_alu_op(input logic [2:0] funct3, input logic alt);
    alu_code_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_alu_decode.sv
// Combinational instruction decoder: maps the instruction register to the
// ALU operation, the operand-B-immediate select and a legality flag.
// Optional feature macro: CTRL_RV32M_EN (accepts R-type funct7=0000001).
// Ports: ir (in, 32), alu_op (out, ALU_OP_W), alu_src_imm (out), legal (out).
module ctrl_alu_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 5
) (
  input  logic [31:0]         ir,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic                legal
);

  instr_t f;
  assign f = ir;

  // Register specifiers play no part in control decoding
  logic unused_regs;
  assign unused_regs = ^{f.rd, f.rs1, f.rs2};

  always_comb begin
    alu_op      = ALU_OP_W'(ALU_ADD);
    alu_src_imm = 1'b0;
    legal       = 1'b0;
    case (f.opcode)
      OPC_OP: begin
        if (f.funct7 == F7_BASE) begin
          legal  = 1'b1;
          alu_op = ALU_OP_W'(base_alu_op(f.funct3, 1'b0));
        end else if (f.funct7 == F7_ALT && (f.funct3 == 3'b000 || f.funct3 == 3'b101)) begin
          legal  = 1'b1;
          alu_op = ALU_OP_W'(base_alu_op(f.funct3, 1'b1));
        end
`ifdef CTRL_RV32M_EN
        else if (f.funct7 == F7_MULDIV) begin
          legal  = 1'b1;
          alu_op = ALU_OP_W'(ALU_MUL + alu_code_t'(f.funct3));
        end
`endif
      end
      // funct7[5] is an immediate bit for ADDI, so it only selects SRAI
      OPC_OP_IMM: begin
        legal       = 1'b1;
        alu_src_imm = 1'b1;
        alu_op      = ALU_OP_W'(base_alu_op(f.funct3, (f.funct3 == 3'b101) && f.funct7[5]));
      end
      OPC_LOAD, OPC_STORE: begin
        legal       = 1'b1;
        alu_src_imm = 1'b1;
      end
      OPC_BRANCH: begin
        legal  = 1'b1;
        alu_op = ALU_OP_W'(ALU_SUB);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 control FSM: FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB),
// with a sticky TRAP for illegal instructions and memory timeouts.
// Optional feature macro: CTRL_RV32M_EN (M-extension ops wait for alu_done).
// Ports: clk, rst_n; imem_req/imem_ready/imem_rdata instruction port;
// dmem_req/dmem_we/dmem_ready data port; alu_done; ir, alu_op, alu_src_imm,
// reg_write, pc_en, trap control outputs; state debug output.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 5,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ready,
  input  logic                alu_done,
  output logic [31:0]         ir,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_imm,
  output logic                reg_write,
  output logic                pc_en,
  output logic                trap,
  output logic [2:0]          state
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [31:0]         ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                imem_req_d, dmem_req_d, dmem_we_d, alu_src_imm_d;
  logic                reg_write_d, pc_en_q, pc_en_d, trap_d;
  logic [ALU_OP_W-1:0] alu_op_d;
  logic                store_done_c;

  logic [ALU_OP_W-1:0] dec_op;
  logic                dec_imm, dec_legal;

  ctrl_alu_decode #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .ir          (ir_q),
    .alu_op      (dec_op),
    .alu_src_imm (dec_imm),
    .legal       (dec_legal)
  );

  logic is_load, is_store, is_branch;
  assign is_load   = (ir_q[6:0] == OPC_LOAD);
  assign is_store  = (ir_q[6:0] == OPC_STORE);
  assign is_branch = (ir_q[6:0] == OPC_BRANCH);

`ifdef CTRL_RV32M_EN
  logic is_mul;
  assign is_mul = (ir_q[6:0] == OPC_OP) && (ir_q[31:25] == F7_MULDIV);
`else
  logic unused_alu_done;
  assign unused_alu_done = alu_done;
`endif

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    store_done_c = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_req) begin
          if (imem_ready) begin
            ir_d    = imem_rdata;
            state_d = ST_DECODE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(MEM_TIMEOUT)) state_d = ST_TRAP;
          end
        end
      end
      ST_DECODE: state_d = dec_legal ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        if (is_load || is_store) state_d = ST_MEM;
        else if (is_branch)      state_d = ST_FETCH;
`ifdef CTRL_RV32M_EN
        else if (!is_mul || alu_done) state_d = ST_WB;
`else
        else                     state_d = ST_WB;
`endif
      end
      ST_MEM: begin
        if (dmem_req) begin
          if (dmem_ready) begin
            store_done_c = is_store;
            state_d      = is_store ? ST_FETCH : ST_WB;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(MEM_TIMEOUT)) state_d = ST_TRAP;
          end
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

    if (state_d != state_q) cnt_d = '0;

    imem_req_d    = (state_d == ST_FETCH);
    dmem_req_d    = (state_d == ST_MEM);
    dmem_we_d     = (state_d == ST_MEM) && is_store;
    reg_write_d   = (state_d == ST_WB);
    trap_d        = (state_d == ST_TRAP);
    // Branch PC strobe covers its single EXECUTE cycle
    pc_en_d       = (state_d == ST_WB) ||
                    ((state_q == ST_DECODE) && (state_d == ST_EXECUTE) && is_branch);
    alu_op_d      = ALU_OP_W'(ALU_ADD);
    alu_src_imm_d = 1'b0;
    if (state_d == ST_EXECUTE || state_d == ST_MEM || state_d == ST_WB) begin
      alu_op_d      = dec_op;
      alu_src_imm_d = dec_imm;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      ir_q        <= '0;
      cnt_q       <= '0;
      imem_req    <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      alu_op      <= '0;
      alu_src_imm <= 1'b0;
      reg_write   <= 1'b0;
      pc_en_q     <= 1'b0;
      trap        <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      imem_req    <= imem_req_d;
      dmem_req    <= dmem_req_d;
      dmem_we     <= dmem_we_d;
      alu_op      <= alu_op_d;
      alu_src_imm <= alu_src_imm_d;
      reg_write   <= reg_write_d;
      pc_en_q     <= pc_en_d;
      trap        <= trap_d;
    end
  end

  // A store retires in the cycle dmem_ready arrives, so that strobe is combinational
  assign pc_en = pc_en_q | store_done_c;
  assign ir    = ir_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit.
module tb_multicycle_control_unit;

  localparam int unsigned S_FETCH = 0, S_DECODE = 1, S_EXEC = 2, S_MEM = 3, S_WB = 4, S_TRAP = 5;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_ADDI = 32'h40008093;
  localparam logic [31:0] I_SRAI = 32'h4010D093;
  localparam logic [31:0] I_XORI = 32'h0040C093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_BADF = 32'h402091B3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic        alu_done = 1'b0;
  logic [31:0] ir;
  logic [4:0]  alu_op;
  logic        alu_src_imm, reg_write, pc_en, trap;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control_unit #(.ALU_OP_W(5), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .alu_done(alu_done), .ir(ir), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
    .reg_write(reg_write), .pc_en(pc_en), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, drive this cycle's inputs, settle before sampling
  task automatic cyc(input logic imr, input logic [31:0] rd, input logic dmr, input logic ad);
    @(posedge clk);
    #1;
    imem_ready = imr; imem_rdata = rd; dmem_ready = dmr; alu_done = ad;
    #1;
  endtask

  task automatic do_reset();
    imem_ready = 1'b0; imem_rdata = '0; dmem_ready = 1'b0; alu_done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic fetch_decode(input logic [31:0] instr, input string name);
    cyc(1'b1, instr, 1'b0, 1'b0);
    check({name, "/fetch_state"}, 32'(state), S_FETCH);
    check({name, "/fetch_req"}, 32'(imem_req), 1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check({name, "/dec_state"}, 32'(state), S_DECODE);
    check({name, "/dec_ir"}, ir, instr);
    check({name, "/dec_req"}, 32'(imem_req), 0);
  endtask

  task automatic run_alu(input logic [31:0] instr, input logic [4:0] exp_op, input logic exp_imm,
                         input string name);
    do_reset();
    fetch_decode(instr, name);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check({name, "/ex_state"}, 32'(state), S_EXEC);
    check({name, "/ex_op"}, 32'(alu_op), 32'(exp_op));
    check({name, "/ex_imm"}, 32'(alu_src_imm), 32'(exp_imm));
    check({name, "/ex_rw"}, 32'(reg_write), 0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check({name, "/wb_state"}, 32'(state), S_WB);
    check({name, "/wb_strobes"}, {30'h0, reg_write, pc_en}, 32'h3);
    check({name, "/wb_op"}, 32'(alu_op), 32'(exp_op));
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check({name, "/post_state"}, 32'(state), S_FETCH);
    check({name, "/post_strobes"}, {30'h0, reg_write, pc_en}, 32'h0);
    check({name, "/post_op"}, {26'h0, alu_src_imm, alu_op}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    // Reset state
    rst_n = 1'b0;
    #3;
    check("rst/state", 32'(state), S_FETCH);
    check("rst/outs", {25'h0, imem_req, dmem_req, dmem_we, alu_src_imm, reg_write, pc_en, trap}, 0);
    check("rst/ir", ir, 0);
    check("rst/alu_op", 32'(alu_op), 0);

    // ADD, with imem_ready high before the request is raised (must be ignored)
    do_reset();
    check("add/rel_req", 32'(imem_req), 0);
    imem_ready = 1'b1; imem_rdata = I_BAD;
    fetch_decode(I_ADD, "add");
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("add/ex_state", 32'(state), S_EXEC);
    check("add/ex_strobes", {30'h0, reg_write, pc_en}, 0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("add/wb_state", 32'(state), S_WB);
    check("add/wb_strobes", {30'h0, reg_write, pc_en}, 32'h3);
    check("add/wb_op", 32'(alu_op), 0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("add/post", {29'h0, imem_req, reg_write, pc_en}, 32'h4);

    run_alu(I_SUB,  5'h01, 1'b0, "sub");
    run_alu(I_OR,   5'h08, 1'b0, "or");
    run_alu(I_ADDI, 5'h00, 1'b1, "addi");
    run_alu(I_SRAI, 5'h07, 1'b1, "srai");
    run_alu(I_XORI, 5'h05, 1'b1, "xori");

    // LW with dmem_ready 3 cycles late; ready during EXECUTE must be ignored
    do_reset();
    fetch_decode(I_LW, "lw");
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("lw/ex_state", 32'(state), S_EXEC);
    check("lw/ex_opimm", {26'h0, alu_src_imm, alu_op}, 32'h20);
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 32'h0, (i == 3), 1'b0);
      check("lw/mem_state", 32'(state), S_MEM);
      check("lw/mem_we", 32'(dmem_we), 0);
      check("lw/mem_pc", 32'(pc_en), 0);
      if (dmem_req) hi++;
    end
    check("lw/req_cycles", 32'(hi), 4);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("lw/wb_state", 32'(state), S_WB);
    check("lw/wb_strobes", {29'h0, dmem_req, reg_write, pc_en}, 32'h3);
    check("lw/wb_imm", 32'(alu_src_imm), 1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("lw/post", {29'h0, imem_req, alu_src_imm, reg_write}, 32'h4);

    // SW, zero-wait
    do_reset();
    fetch_decode(I_SW, "sw");
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("sw/ex_opimm", {26'h0, alu_src_imm, alu_op}, 32'h20);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);
    check("sw/mem_state", 32'(state), S_MEM);
    check("sw/mem_sig", {28'h0, dmem_req, dmem_we, pc_en, reg_write}, 32'hE);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("sw/post_state", 32'(state), S_FETCH);
    check("sw/post_sig", {28'h0, dmem_req, dmem_we, pc_en, reg_write}, 0);

    // BEQ: pc_en during the single EXECUTE cycle
    do_reset();
    fetch_decode(I_BEQ, "beq");
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("beq/ex_state", 32'(state), S_EXEC);
    check("beq/ex_op", 32'(alu_op), 1);
    check("beq/ex_strobes", {30'h0, reg_write, pc_en}, 32'h1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("beq/post", {29'h0, imem_req, pc_en, 1'b0}, 32'h4);
    check("beq/post_state", 32'(state), S_FETCH);

    // Illegal opcode: sticky TRAP, inputs ignored
    do_reset();
    fetch_decode(I_BAD, "bad");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, I_ADD, 1'b1, 1'b1);
      check("bad/state", 32'(state), S_TRAP);
      check("bad/outs", {27'h0, trap, imem_req, dmem_req, reg_write, pc_en}, 32'h10);
    end

    // R-type SUB-style funct7 with funct3=001 is illegal
    do_reset();
    fetch_decode(I_BADF, "badf");
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("badf/state", 32'(state), S_TRAP);
    check("badf/trap", 32'(trap), 1);

    // MUL
    do_reset();
    fetch_decode(I_MUL, "mul");
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef CTRL_RV32M_EN
    check("mul/ex_op", 32'(alu_op), 32'h10);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      check("mul/wait_state", 32'(state), S_EXEC);
      check("mul/wait_rw", 32'(reg_write), 0);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check("mul/done_state", 32'(state), S_EXEC);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("mul/wb_state", 32'(state), S_WB);
    check("mul/wb_op", 32'(alu_op), 32'h10);
    check("mul/wb_rw", 32'(reg_write), 1);
`else
    check("mul/state", 32'(state), S_TRAP);
    check("mul/trap", 32'(trap), 1);
`endif

    // Fetch timeout: 16 request cycles with no ready
    do_reset();
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      if (imem_req && state == 3'(S_FETCH)) hi++;
    end
    check("ito/req_cycles", 32'(hi), 16);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("ito/state", 32'(state), S_TRAP);
    check("ito/outs", {30'h0, trap, imem_req}, 32'h2);

    // Data timeout on a load
    do_reset();
    fetch_decode(I_LW, "dto");
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      if (dmem_req) hi++;
    end
    check("dto/req_cycles", 32'(hi), 16);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("dto/state", 32'(state), S_TRAP);
    check("dto/outs", {30'h0, trap, dmem_req}, 32'h2);

    // Reset mid-MEM
    do_reset();
    fetch_decode(I_LW, "rmem");
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("rmem/pre_req", 32'(dmem_req), 1);
    rst_n = 1'b0;
    #1;
    check("rmem/req_async", 32'(dmem_req), 0);
    check("rmem/state_async", 32'(state), S_FETCH);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    check("rmem/rel_state", 32'(state), S_FETCH);
    check("rmem/rel_req", 32'(imem_req), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
